// File: rtl/twobit_wrap_monitor.sv
// Monitors a free-running 2-bit upstream counter: counts 3->0 wraps modulo WRAP_MAX
// and flags illegal steps. Define WRAP_MON_ERRCNT_EN to add the saturating err_cnt.
module twobit_wrap_monitor #(
  parameter int WRAP_MAX = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q2,
  input  logic             q1,
  input  logic             en,
  input  logic             clr_err,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             wrap_pulse,
  output logic             tc_pulse,
  output logic             seq_err,
  output logic [3:0]       err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    TRACK = 2'b01,
    ERR   = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] WRAP_LAST = CNT_W'(WRAP_MAX - 1);

  state_e           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             tc_pulse_q, tc_pulse_d;
  logic             seq_err_q, seq_err_d;
  logic             illegal;

  logic [1:0] cur;
  logic [1:0] prev_inc;
  assign cur      = {q2, q1};
  assign prev_inc = prev_q + 2'd1;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_pulse_d = 1'b0;
    tc_pulse_d   = 1'b0;
    seq_err_d    = seq_err_q;
    illegal      = 1'b0;

    if (clr_err) begin
      // Clearing wins over a same-edge sample; wrap_cnt deliberately survives.
      state_d   = INIT;
      seq_err_d = 1'b0;
    end else if (en) begin
      unique case (state_q)
        INIT: begin
          prev_d  = cur;
          state_d = TRACK;
        end
        TRACK: begin
          if (cur == prev_q) begin
            // hold: legal, no effect
          end else if (cur == prev_inc) begin
            prev_d = cur;
            if (prev_q == 2'd3) begin
              wrap_pulse_d = 1'b1;
              if (wrap_cnt_q == WRAP_LAST) begin
                wrap_cnt_d = '0;
                tc_pulse_d = 1'b1;
              end else begin
                wrap_cnt_d = wrap_cnt_q + 1'b1;
              end
            end
          end else begin
            illegal   = 1'b1;
            prev_d    = cur;
            seq_err_d = 1'b1;
            state_d   = ERR;
          end
        end
        ERR: begin
          // wrap detection suspended until clr_err
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= INIT;
      prev_q       <= 2'd0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
      tc_pulse_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      tc_pulse_q   <= tc_pulse_d;
      seq_err_q    <= seq_err_d;
    end
  end

`ifdef WRAP_MON_ERRCNT_EN
  logic [3:0] err_cnt_q;

  // Saturates at 15; only rst clears it, clr_err leaves the history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 4'd0;
    end else if (illegal && (err_cnt_q != 4'd15)) begin
      err_cnt_q <= err_cnt_q + 4'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign err_cnt        = 4'd0;
`endif

  assign wrap_cnt   = wrap_cnt_q;
  assign wrap_pulse = wrap_pulse_q;
  assign tc_pulse   = tc_pulse_q;
  assign seq_err    = seq_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_twobit_wrap_monitor.sv
// Scoreboard bench for twobit_wrap_monitor: stimulus pushes hand-derived expectations,
// a monitor pops and compares one entry per clock. Honours WRAP_MON_ERRCNT_EN.
module tb_twobit_wrap_monitor;

  localparam logic [1:0] S_INIT  = 2'b00;
  localparam logic [1:0] S_TRACK = 2'b01;
  localparam logic [1:0] S_ERR   = 2'b10;

  typedef struct packed {
    logic [7:0] wc;
    logic       wp;
    logic       tc;
    logic       se;
    logic [3:0] ec;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, q2, q1, en, clr_err;
  logic [7:0] wrap_cnt;
  logic       wrap_pulse, tc_pulse, seq_err;
  logic [3:0] err_cnt;
  logic [1:0] state;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   exp_err = 0;

  twobit_wrap_monitor #(.WRAP_MAX(10), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .q2(q2), .q1(q1), .en(en), .clr_err(clr_err),
    .wrap_cnt(wrap_cnt), .wrap_pulse(wrap_pulse), .tc_pulse(tc_pulse),
    .seq_err(seq_err), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if ({wrap_cnt, wrap_pulse, tc_pulse, seq_err, err_cnt, state} !== e) begin
      n_fail++;
      $display("FAIL %s: got wc=%0d wp=%b tc=%b se=%b ec=%0d st=%b, want wc=%0d wp=%b tc=%b se=%b ec=%0d st=%b",
               name, wrap_cnt, wrap_pulse, tc_pulse, seq_err, err_cnt, state,
               e.wc, e.wp, e.tc, e.se, e.ec, e.st);
    end
  endtask

  // Monitor: outputs are registered, so each edge presents one result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check($sformatf("vec%0d", n_vec), exp_q.pop_front());
    end
  end

  function automatic int bump_err(input int v);
`ifdef WRAP_MON_ERRCNT_EN
    return (v < 15) ? v + 1 : 15;
`else
    return v;
`endif
  endfunction

  task automatic vec(input logic r, input logic e, input logic c, input logic [1:0] q,
                     input int wc, input logic wp, input logic tc, input logic se,
                     input logic [1:0] st);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; clr_err = c; {q2, q1} = q;
    if (r) exp_err = 0;
    x.wc = 8'(wc); x.wp = wp; x.tc = tc; x.se = se; x.ec = 4'(exp_err); x.st = st;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; {q2, q1} = 2'd0;

    // Reset, including en/clr_err being ignored under reset
    vec(1, 0, 0, 2'd0, 0, 0, 0, 0, S_INIT);
    vec(1, 1, 1, 2'd3, 0, 0, 0, 0, S_INIT);

    // 0,1,2,3,0: one wrap
    vec(0, 1, 0, 2'd0, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd1, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd2, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd3, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd0, 1, 1, 0, 0, S_TRACK);
    vec(0, 0, 0, 2'd0, 1, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd0, 1, 0, 0, 0, S_TRACK);

    // Ten full cycles from reset: terminal count on the 10th wrap
    vec(1, 0, 0, 2'd0, 0, 0, 0, 0, S_INIT);
    vec(0, 1, 0, 2'd0, 0, 0, 0, 0, S_TRACK);
    for (int w = 1; w <= 10; w++) begin
      vec(0, 1, 0, 2'd1, w - 1, 0, 0, 0, S_TRACK);
      vec(0, 1, 0, 2'd2, w - 1, 0, 0, 0, S_TRACK);
      vec(0, 1, 0, 2'd3, w - 1, 0, 0, 0, S_TRACK);
      vec(0, 1, 0, 2'd0, w % 10, 1, (w == 10), 0, S_TRACK);
    end

    // 0,1,3: illegal +2, then 3->0 inside ERR is not a wrap
    vec(0, 1, 0, 2'd0, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd1, 0, 0, 0, 0, S_TRACK);
    exp_err = bump_err(exp_err);
    vec(0, 1, 0, 2'd3, 0, 0, 0, 1, S_ERR);
    vec(0, 1, 0, 2'd0, 0, 0, 0, 1, S_ERR);

    // clr_err while q=2 (sample ignored), then 2,3,0 wraps once
    vec(0, 1, 1, 2'd2, 0, 0, 0, 0, S_INIT);
    vec(0, 1, 0, 2'd2, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd3, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd0, 1, 1, 0, 0, S_TRACK);

    // Hold pattern 1,1,1,2 with en 1,0,1,1
    vec(0, 1, 0, 2'd1, 1, 0, 0, 0, S_TRACK);
    vec(0, 0, 0, 2'd1, 1, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd1, 1, 0, 0, 0, S_TRACK);
    vec(0, 1, 0, 2'd2, 1, 0, 0, 0, S_TRACK);

    // clr_err in TRACK returns to INIT
    vec(0, 0, 1, 2'd2, 1, 0, 0, 0, S_INIT);
    vec(0, 1, 0, 2'd2, 1, 0, 0, 0, S_TRACK);

    // Reset on the edge capturing 3->0 discards the wrap
    vec(0, 1, 0, 2'd3, 1, 0, 0, 0, S_TRACK);
    vec(1, 1, 0, 2'd0, 0, 0, 0, 0, S_INIT);
    vec(0, 1, 0, 2'd2, 0, 0, 0, 0, S_TRACK);
    vec(0, 1, 1, 2'd2, 0, 0, 0, 0, S_INIT);

    // 20 illegal transitions (0->2 and 3->1, neither counted as a wrap)
    for (int i = 0; i < 20; i++) begin
      logic [1:0] b;
      b = (i % 2 == 1) ? 2'd3 : 2'd0;
      vec(0, 1, 0, b, 0, 0, 0, 0, S_TRACK);
      exp_err = bump_err(exp_err);
      vec(0, 1, 0, b + 2'd2, 0, 0, 0, 1, S_ERR);
      vec(0, 0, 1, b, 0, 0, 0, 0, S_INIT);
    end

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
